fetch_unit: RTL and testbench

//  Instruction-fetch front end for the RV32I core. Issues word fetches to an instruction memory over a

---
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect input, fetch enable and the decode-side instruction handshake.
interface fetch_if;
    logic        fetch_en;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // fetch unit side
    modport master (
        input  fetch_en, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redirect_valid, redirect_pc, instr_ready,
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
    );

    // memory / core side
    modport slave (
        output fetch_en, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               redirect_valid, redirect_pc, instr_ready,
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: issues word fetches, buffers in-order
// responses with their PCs in a DEPTH-entry FIFO, flushes on redirect and
// drops responses belonging to the squashed stream.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];

    logic [CW:0]     in_use;
    logic            req_valid, req_fire, push, pop, fifo_nonempty;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = ^bus.redirect_pc[1:0];

    // Slots reserved = buffered entries + every request still in flight,
    // so a response always finds room and the FIFO cannot overflow.
    assign in_use        = {1'b0, count_q} + {1'b0, outst_q};
    assign req_valid     = (state_q == RUN) && bus.fetch_en && !bus.redirect_valid
                           && (in_use < DEPTH_C);
    assign req_fire      = req_valid && bus.mem_req_ready;
    assign fifo_nonempty = (count_q != '0);
    assign push          = bus.mem_rsp_valid && !bus.redirect_valid && (discard_q == '0);
    assign pop           = fifo_nonempty && bus.instr_ready && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.instr_valid   = fifo_nonempty;
    assign bus.instr         = fifo_nonempty ? data_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc      = fifo_nonempty ? pc_q[rd_ptr_q]   : 32'h0;

    // Run/idle tracking of fetch enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.fetch_en)  state_d = RUN;
            RUN:     if (!bus.fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next-state for PCs, FIFO pointers and in-flight bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {bus.redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Every request still in flight after this edge belongs to the
            // dead stream; outstanding already covers any earlier discards,
            // so back-to-back redirects do not double count.
            discard_d  = outst_d;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (bus.mem_rsp_valid && (discard_q != '0))
                discard_d = discard_q - 1'b1;
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage: instruction word plus the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                pc_q[i]   <= 32'h0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= bus.mem_rsp_data;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    // A live response must never land on a full FIFO unless a pop frees a slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> ((count_q != DEPTH_C[CW-1:0]) || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model with per-request latency
// and a stream-epoch reference model predicting every request and every
// delivered instruction.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

    mreq_t       mq[$];   // requests accepted by memory, oldest first
    ent_t        fq[$];   // instructions the unit should be holding
    int          epoch, cyc, n_chk, n_err;
    logic [31:0] m_fetch_pc;
    bit          m_run;
    int          lat_min, lat_max, p_rdy, p_irdy, p_redir, p_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rdy, input int irdy,
                         input int redir, input int en);
        lat_min = lmin; lat_max = lmax; p_rdy = rdy; p_irdy = irdy; p_redir = redir; p_en = en;
    endtask

    task automatic idle_inputs;
        bus.fetch_en       = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic model_reset;
        mq.delete();
        fq.delete();
        m_fetch_pc = RESET_PC;
        m_run      = 1'b0;
        epoch++;
    endtask

    task automatic check_reset_outputs(input string who);
        check({who, "_req_valid"},   32'(bus.mem_req_valid), 32'h0);
        check({who, "_instr_valid"}, 32'(bus.instr_valid),   32'h0);
        check({who, "_instr"},       bus.instr,              32'h0);
        check({who, "_instr_pc"},    bus.instr_pc,           32'h0);
        check({who, "_req_addr"},    bus.mem_req_addr,       RESET_PC);
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance the model
    // by what the coming rising edge does.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit    en, rdy, irdy, rsp, exp_req;
        mreq_t m;
        @(negedge clk);
        en   = ($urandom_range(99) < p_en);
        rdy  = ($urandom_range(99) < p_rdy);
        irdy = ($urandom_range(99) < p_irdy);
        rsp  = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.fetch_en       = en;
        bus.mem_req_ready  = rdy;
        bus.instr_ready    = irdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.mem_rsp_valid  = rsp;
        bus.mem_rsp_data   = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        exp_req = m_run && en && !redir && ((fq.size() + mq.size()) < DEPTH);
        check("req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", bus.mem_req_addr, m_fetch_pc);
        check("instr_valid", 32'(bus.instr_valid), 32'(fq.size() != 0));
        check("instr",    bus.instr,    (fq.size() != 0) ? fq[0].data : 32'h0);
        check("instr_pc", bus.instr_pc, (fq.size() != 0) ? fq[0].pc   : 32'h0);

        if (rsp) m = mq.pop_front();
        if (redir) begin
            fq.delete();
            epoch++;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if ((fq.size() != 0) && irdy) void'(fq.pop_front());
            if (rsp && (m.epoch == epoch)) fq.push_back('{mem_word(m.addr), m.addr});
            if (exp_req && rdy) begin
                mq.push_back('{m_fetch_pc, epoch, cyc + $urandom_range(lat_max, lat_min)});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        m_run = en;
        cyc++;
    endtask

    task automatic run(input int n);
        bit          redir;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            redir = ($urandom_range(99) < p_redir);
            rpc   = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            cycle(redir, rpc);
        end
    endtask

    task automatic reset_mid;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; epoch = 0;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // streaming, latency 1, always ready
        knobs(1, 1, 100, 100, 0, 100);
        run(60);
        // consumer stalled: requests stop at DEPTH, then drain and resume
        knobs(1, 1, 100, 0, 0, 100);
        run(20);
        knobs(1, 1, 100, 100, 0, 100);
        run(20);
        // latency 3 with a redirect mid-flight, low bits ignored
        knobs(3, 3, 100, 100, 0, 100);
        run(6);
        cycle(1'b1, 32'h103);
        run(20);
        // back-to-back redirects
        run(4);
        cycle(1'b1, 32'h40);
        cycle(1'b1, 32'h80);
        run(20);
        // address wrap
        cycle(1'b1, 32'hFFFF_FFF8);
        run(20);
        // random traffic with varied latency, backpressure and redirects
        knobs(1, 5, 70, 60, 5, 100);
        run(1500);
        knobs(2, 6, 80, 80, 30, 100);
        run(1500);
        knobs(1, 4, 60, 50, 5, 85);
        run(1500);
        // fill the FIFO then reset in the middle of traffic
        knobs(2, 2, 100, 0, 0, 100);
        run(5);
        reset_mid();
        knobs(1, 4, 70, 70, 8, 95);
        run(1500);
        reset_mid();
        knobs(1, 1, 100, 100, 0, 100);
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
